simple_mul: RTL and testbench

Signed 32×32→64-bit two's-complement multiplier for the ALU datapath. It provides a full-width combinational product for single-cycle ALU use. It also provides a registered copy of that product for pipelined consumers. The product is built from radix-4 Booth partial products and a carry-save reduction tree, without any behavioural `*` operator.

---
 rtl/simple_mul_pkg.sv | 37 +++
 rtl/simple_mul_booth_pp_gen.sv | 38 +++
 rtl/simple_mul.sv | 86 ++++++++
 tb/tb_simple_mul.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/simple_mul_pkg.sv
// Shared widths, Booth digit encoding and reduction-tree sizing for simple_mul.
// Helper functions are elaboration-time only.
package simple_mul_pkg;

  localparam int OP_W     = 32;
  localparam int PROD_W   = 64;
  localparam int NUM_PP   = 16;
  localparam int PP_W     = OP_W + 2;
  localparam int NUM_ROWS = NUM_PP + 1;
  localparam int CSA_LVLS = 6;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Number of rows still live at the input of a given 3:2 level.
  function automatic int rows_at(input int lvl);
    int n;
    n = NUM_ROWS;
    for (int k = 0; k < lvl; k++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  // Each partial product carries its inverted sign bit at column 33+2i;
  // this constant subtracts the 2^(33+2i) that inversion adds back.
  function automatic logic [PROD_W-1:0] sign_corr();
    logic [PROD_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PP; i++) c = c - (64'd1 << (PP_W - 1 + 2 * i));
    return c;
  endfunction

endpackage

// File: rtl/simple_mul_booth_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +-A or +-2A at 34 bits.
// Negation is one's complement here; the +1 leaves through the neg output.
module booth_pp_gen
  import simple_mul_pkg::*;
(
  input  logic [2:0]      grp,
  input  logic [OP_W-1:0] a,
  output logic [PP_W-1:0] pp,
  output logic            neg
);

  booth_digit_t digit;
  logic [PP_W-1:0] mag;

  always_comb begin
    case (grp)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (digit)
      POS1: mag = {{2{a[OP_W-1]}}, a};
      POS2: mag = {a[OP_W-1], a, 1'b0};
      NEG1: begin mag = {{2{a[OP_W-1]}}, a}; neg = 1'b1; end
      NEG2: begin mag = {a[OP_W-1], a, 1'b0}; neg = 1'b1; end
      default: begin mag = '0; neg = 1'b0; end
    endcase
    pp = neg ? ~mag : mag;
  end

endmodule

// File: rtl/simple_mul.sv
// Signed 32x32->64 Booth/CSA multiplier with combinational and registered product.
// Optional overflow flag (Ovf, Ovf_r) is built only when SIMPLE_MUL_OVF_EN is defined.
module simple_mul
  import simple_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Product,
  output logic [PROD_W-1:0] Product_r
`ifdef SIMPLE_MUL_OVF_EN
  ,
  output logic              Ovf,
  output logic              Ovf_r
`endif
);

  localparam logic [PROD_W-1:0] SIGN_CORR = sign_corr();

  logic [OP_W:0]       b_ext;
  logic [PP_W-1:0]     pp  [NUM_PP];
  logic [NUM_PP-1:0]   neg;
  logic [PROD_W-1:0]   neg_vec;
  logic [PROD_W-1:0]   row [CSA_LVLS+1][NUM_ROWS];

  // B[-1] = 0 sits below the LSB; with 32 bits the top group already ends at B[31].
  assign b_ext = {B, 1'b0};

  genvar i, l, g, r;
  generate
    for (i = 0; i < NUM_PP; i++) begin : g_pp
      booth_pp_gen u_pp (
        .grp (b_ext[2*i+2 -: 3]),
        .a   (A),
        .pp  (pp[i]),
        .neg (neg[i])
      );
      assign row[0][i] = PROD_W'({~pp[i][PP_W-1], pp[i][PP_W-2:0]}) << (2 * i);
    end
  endgenerate

  // Negate bits land on even columns 0..30 and the sign constant starts at
  // column 33, so both share one row without collision.
  always_comb begin
    neg_vec = '0;
    for (int k = 0; k < NUM_PP; k++) neg_vec[2*k] = neg[k];
  end
  assign row[0][NUM_PP] = neg_vec | SIGN_CORR;

  generate
    for (l = 0; l < CSA_LVLS; l++) begin : g_lvl
      localparam int N  = rows_at(l);
      localparam int NN = rows_at(l + 1);
      for (g = 0; g < N / 3; g++) begin : g_csa
        assign row[l+1][2*g] = row[l][3*g] ^ row[l][3*g+1] ^ row[l][3*g+2];
        assign row[l+1][2*g+1] = ((row[l][3*g]   & row[l][3*g+1]) |
                                  (row[l][3*g]   & row[l][3*g+2]) |
                                  (row[l][3*g+1] & row[l][3*g+2])) << 1;
      end
      for (r = 0; r < N % 3; r++) begin : g_pass
        assign row[l+1][2*(N/3)+r] = row[l][3*(N/3)+r];
      end
      for (r = NN; r < NUM_ROWS; r++) begin : g_zero
        assign row[l+1][r] = '0;
      end
    end
  endgenerate

  assign Product = row[CSA_LVLS][0] + row[CSA_LVLS][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Product_r <= '0;
    else     Product_r <= Product;
  end

`ifdef SIMPLE_MUL_OVF_EN
  assign Ovf = ~((&Product[PROD_W-1:OP_W-1]) | ~(|Product[PROD_W-1:OP_W-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Ovf_r <= 1'b0;
    else     Ovf_r <= Ovf;
  end
`endif

endmodule

// File: tb/tb_simple_mul.sv
// Directed bench for simple_mul: hand-computed vectors, corners, reset and random sweep.
module tb_simple_mul;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] Product;
  logic [63:0] Product_r;
`ifdef SIMPLE_MUL_OVF_EN
  logic        Ovf;
  logic        Ovf_r;
`endif

  int total = 0;
  int bad   = 0;

  simple_mul dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Product   (Product),
    .Product_r (Product_r)
`ifdef SIMPLE_MUL_OVF_EN
    ,
    .Ovf       (Ovf),
    .Ovf_r     (Ovf_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, check the combinational product,
  // then check the registered copy just after the next rising edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    #1;
    check({tag, "_comb"}, Product, exp);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, Product_r, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    A = 32'd0;
    B = 32'd0;
    #12;
    check("reset_state", Product_r, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    apply("m20_n3",     32'd20,              -32'sd3,      64'hFFFF_FFFF_FFFF_FFC4);
    apply("m77_88",     32'd77,              32'd88,       64'h0000_0000_0000_1A78);
    apply("n90_n90",    -32'sd90,            -32'sd90,     64'h0000_0000_0000_1FA4);
    apply("n100_99",    -32'sd100,           32'd99,       64'hFFFF_FFFF_FFFF_D954);
    apply("zero_b",     32'd0,               32'd98765,    64'h0000_0000_0000_0000);
    apply("one_b",      32'd1,               32'd98765,    64'h0000_0000_0001_81CD);
    apply("n200_4008",  -32'sd200,           32'd4008,     64'hFFFF_FFFF_FFF3_C4C0);
    apply("n111_n2222", -32'sd111,           -32'sd2222,   64'h0000_0000_0003_C372);
    apply("swap_4008",  32'd4008,            -32'sd200,    64'hFFFF_FFFF_FFF3_C4C0);

    apply("min_min",    32'h8000_0000,       32'h8000_0000, 64'h4000_0000_0000_0000);
`ifdef SIMPLE_MUL_OVF_EN
    check("ovf_min_min", {63'd0, Ovf}, 64'd1);
    check("ovf_r_min_min", {63'd0, Ovf_r}, 64'd1);
`endif
    apply("max_min",    32'h7FFF_FFFF,       32'h8000_0000, 64'hC000_0000_8000_0000);
`ifdef SIMPLE_MUL_OVF_EN
    check("ovf_max_min", {63'd0, Ovf}, 64'd1);
`endif
    apply("min_max",    32'h8000_0000,       32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    apply("neg1_neg1",  32'hFFFF_FFFF,       32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
`ifdef SIMPLE_MUL_OVF_EN
    check("ovf_neg1", {63'd0, Ovf}, 64'd0);
    check("ovf_r_neg1", {63'd0, Ovf_r}, 64'd0);
`endif

    // Mid-cycle reset clears only the register; the combinational path keeps going.
    apply("pre_rst",    32'd77,              32'd88,       64'h0000_0000_0000_1A78);
    @(negedge clk);
    A = -32'sd90;
    B = -32'sd90;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_reg", Product_r, 64'd0);
    check("rst_comb_live", Product, 64'h0000_0000_0000_1FA4);
`ifdef SIMPLE_MUL_OVF_EN
    check("rst_ovf_r", {63'd0, Ovf_r}, 64'd0);
`endif
    @(posedge clk);
    #1;
    check("rst_hold_reg", Product_r, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_reg", Product_r, 64'h0000_0000_0000_1FA4);

    for (int k = 0; k < 400; k++) begin
      ra = $urandom;
      rb = $urandom;
      case (k % 8)
        1: ra = 32'h8000_0000;
        3: rb = 32'h7FFF_FFFF;
        5: begin ra = 32'h7FFF_FFFF; rb = 32'h8000_0000; end
        default: ;
      endcase
      @(negedge clk);
      A = ra;
      B = rb;
      #1;
      check("random", Product, ref_mul(ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
